// File: rtl/tdc_pkg.sv
// Shared constants and helpers for the TDC thermometer encoder.
package tdc_pkg;

    localparam logic MODE_RAW  = 1'b0;
    localparam logic MODE_FILT = 1'b1;

    // Smallest n such that 2^n >= value (value >= 1).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned n;
        n = 0;
        for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
            n = n + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/tdc_thermo_lane.sv
// One TDC channel: snapshot register, bubble filter, pipelined bisection and flag outputs.
module tdc_thermo_lane
    import tdc_pkg::*;
#(
    parameter int unsigned WIDTH = 40,
    localparam int unsigned L    = clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data,
    input  logic             mode,
    input  logic             load,
    output logic [L-1:0]     code,
    output logic             err,
    output logic             ovf
);

    localparam int unsigned P  = 2 ** L;
    localparam int unsigned PW = P - 1;

    logic [WIDTH-1:0] d0_q;
    logic [WIDTH+1:0] ext;
    logic [WIDTH-1:0] filt;
    logic             err_c;
    logic [PW-1:0]    filt_q;
    logic             err_f_q;

    // Stage 0: capture the raw delay-line snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d0_q <= '0;
        end else begin
            d0_q <= data;
        end
    end

    // Majority filter with virtual 1 below tap 0 and virtual 0 above the top tap; bubble detect.
    always_comb begin
        ext   = {1'b0, d0_q, 1'b1};
        filt  = d0_q;
        err_c = 1'b0;
        if (mode == MODE_FILT) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                filt[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
            end
        end
        for (int i = 0; i < int'(WIDTH) - 1; i++) begin
            err_c = err_c | (~filt[i] & filt[i+1]);
        end
    end

    // Stage F: zero-padded filtered vector; the top padded bit is never probed so it is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q  <= '0;
            err_f_q <= 1'b0;
        end else begin
            filt_q  <= PW'(filt);
            err_f_q <= err_c;
        end
    end

    // Bisection: stage j probes the middle bit of its window and keeps the surviving half.
    for (genvar j = 0; j < int'(L); j++) begin : g_stg
        localparam int unsigned IW = (2 ** (j + 1)) - 1;
        localparam int unsigned OW = (2 ** j) - 1;

        logic [IW-1:0] win_in;
        logic [L-1:0]  k_in;
        logic          err_in;
        logic          hit;
        logic [L-1:0]  k_q;
        logic          err_q;

        if (j == int'(L) - 1) begin : g_src
            assign win_in = filt_q;
            assign k_in   = '0;
            assign err_in = err_f_q;
        end else begin : g_src
            assign win_in = g_stg[j+1].g_win.win_q;
            assign k_in   = g_stg[j+1].k_q;
            assign err_in = g_stg[j+1].err_q;
        end

        assign hit = win_in[OW];

        // Partial code and the bubble flag advance together.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                k_q   <= '0;
                err_q <= 1'b0;
            end else begin
                k_q   <= hit ? (k_in | (L'(1) << j)) : k_in;
                err_q <= err_in;
            end
        end

        if (j > 0) begin : g_win
            logic [OW-1:0] win_q;

            // Upper half when the probe bit is set, lower half otherwise.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    win_q <= '0;
                end else begin
                    win_q <= hit ? win_in[IW-1 -: OW] : win_in[OW-1:0];
                end
            end
        end
    end

    // Output stage: update only for valid samples so results hold between them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code <= '0;
            err  <= 1'b0;
            ovf  <= 1'b0;
        end else if (load) begin
            code <= g_stg[0].k_q;
            err  <= g_stg[0].err_q;
            ovf  <= (g_stg[0].k_q == L'(WIDTH));
        end
    end

endmodule

// File: rtl/tdc_thermo_encoder.sv
// Multi-channel pipelined thermometer-to-binary encoder for the TDC delay-line front end.
module tdc_thermo_encoder
    import tdc_pkg::*;
#(
    parameter int unsigned CH    = 2,
    parameter int unsigned WIDTH = 40,
    localparam int unsigned L    = clog2(WIDTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic              mode_in,
    input  logic [CH*WIDTH-1:0] data_in,
    output logic              valid_out,
    output logic [CH*L-1:0]   code_out,
    output logic [CH-1:0]     err_out,
    output logic [CH-1:0]     ovf_out
);

    // vld_q[0] = stage 0, vld_q[1] = filter stage, vld_q[2..L+1] = bisection stages.
    logic [L+1:0] vld_q;
    logic         mode_q;

    // Shared valid shift register and per-sample mode capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q     <= '0;
            mode_q    <= MODE_RAW;
            valid_out <= 1'b0;
        end else begin
            vld_q     <= {vld_q[L:0], valid_in};
            mode_q    <= mode_in;
            valid_out <= vld_q[L+1];
        end
    end

    for (genvar c = 0; c < int'(CH); c++) begin : g_lane
        tdc_thermo_lane #(
            .WIDTH (WIDTH)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .data  (data_in[c*WIDTH +: WIDTH]),
            .mode  (mode_q),
            .load  (vld_q[L+1]),
            .code  (code_out[c*L +: L]),
            .err   (err_out[c]),
            .ovf   (ovf_out[c])
        );
    end

endmodule

// File: tb/tb_tdc_thermo_encoder.sv
// Self-checking bench for tdc_thermo_encoder (CH=2, WIDTH=40).
module tb_tdc_thermo_encoder;

    localparam int unsigned CH  = 2;
    localparam int unsigned W   = 40;
    localparam int unsigned L   = tdc_pkg::clog2(W + 1);
    localparam int unsigned P   = 2 ** L;
    localparam int unsigned LAT = L + 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              valid_in;
    logic              mode_in;
    logic [CH*W-1:0]   data_in;
    logic              valid_out;
    logic [CH*L-1:0]   code_out;
    logic [CH-1:0]     err_out;
    logic [CH-1:0]     ovf_out;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int              cyc;
        logic [CH*L-1:0] code;
        logic [CH-1:0]   err;
        logic [CH-1:0]   ovf;
    } exp_t;

    exp_t q[$];

    tdc_thermo_encoder #(.CH(CH), .WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .mode_in   (mode_in),
        .data_in   (data_in),
        .valid_out (valid_out),
        .code_out  (code_out),
        .err_out   (err_out),
        .ovf_out   (ovf_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference for one channel: returns {err, code}, computed straight from the encoding rules.
    function automatic logic [L:0] model_lane(input logic [W-1:0] b, input logic m);
        logic pad [P];
        int   k;
        int   s;
        logic lo, hi, e;
        for (int i = 0; i < int'(P); i++) pad[i] = 1'b0;
        for (int i = 0; i < int'(W); i++) begin
            if (m) begin
                lo = (i == 0) ? 1'b1 : b[i-1];
                hi = (i == int'(W) - 1) ? 1'b0 : b[i+1];
                s  = int'(lo) + int'(b[i]) + int'(hi);
                pad[i] = (s >= 2);
            end else begin
                pad[i] = b[i];
            end
        end
        e = 1'b0;
        for (int i = 0; i < int'(W) - 1; i++) begin
            if (!pad[i] && pad[i+1]) e = 1'b1;
        end
        k = 0;
        for (int j = int'(L) - 1; j >= 0; j--) begin
            if (pad[(k | (1 << j)) - 1]) k = k | (1 << j);
        end
        return {e, L'(k)};
    endfunction

    function automatic exp_t model_all(input logic [CH*W-1:0] d, input logic m, input int vis);
        exp_t     x;
        logic [L:0] r;
        x.cyc = vis;
        for (int c = 0; c < int'(CH); c++) begin
            r = model_lane(d[c*W +: W], m);
            x.code[c*L +: L] = r[L-1:0];
            x.err[c]         = r[L];
            x.ovf[c]         = (r[L-1:0] == L'(W));
        end
        return x;
    endfunction

    function automatic logic [W-1:0] gen_vec();
        logic [W-1:0]  v;
        logic [63:0]   r;
        int            n;
        int            p;
        n = $urandom_range(0, W);
        v = '0;
        for (int i = 0; i < n; i++) v[i] = 1'b1;
        case ($urandom_range(0, 3))
            1: begin
                p = $urandom_range(0, W - 1);
                v[p] = ~v[p];
            end
            2: begin
                p = $urandom_range(0, W - 2);
                v[p]   = ~v[p];
                v[p+1] = ~v[p+1];
            end
            3: begin
                r = {$urandom, $urandom};
                v = r[W-1:0];
            end
            default: ;
        endcase
        return v;
    endfunction

    task automatic test_reset();
        rst_n    = 1'b0;
        valid_in = 1'b0;
        mode_in  = 1'b0;
        data_in  = '0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (n >= 2) begin
                checks++;
                if (valid_out !== 1'b0 || code_out !== '0 || err_out !== '0 || ovf_out !== '0) begin
                    errors++;
                    $display("FAIL reset_hold: v=%b code=%h err=%b ovf=%b, want all zero",
                             valid_out, code_out, err_out, ovf_out);
                end
            end
            valid_in = 1'($urandom);
            mode_in  = 1'($urandom);
            data_in  = {$urandom, $urandom, $urandom};
        end
        valid_in = 1'b0;
        rst_n    = 1'b1;
        for (int n = 0; n < int'(LAT) + 4; n++) begin
            @(negedge clk);
            checks++;
            if (valid_out !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle: valid_out=%b, want 0", valid_out);
            end
        end
    endtask

    // Send one sample, check exact latency, values and that results hold afterwards.
    task automatic pulse_and_check(input string name, input logic [CH*W-1:0] d, input logic m,
                                   input int c0, input int c1,
                                   input logic [1:0] e, input logic [1:0] o);
        logic [CH*L-1:0] exp_code;
        exp_code = {L'(c1), L'(c0)};
        @(negedge clk);
        valid_in = 1'b1;
        mode_in  = m;
        data_in  = d;
        for (int n = 1; n <= int'(LAT) + 1; n++) begin
            @(negedge clk);
            checks++;
            if (valid_out !== (n == int'(LAT))) begin
                errors++;
                $display("FAIL %s latency: cycle %0d valid_out=%b, want %b",
                         name, n, valid_out, (n == int'(LAT)));
            end
            if (n == int'(LAT)) begin
                checks++;
                if (code_out !== exp_code || err_out !== e || ovf_out !== o) begin
                    errors++;
                    $display("FAIL %s value: code=%h err=%b ovf=%b, want code=%h err=%b ovf=%b",
                             name, code_out, err_out, ovf_out, exp_code, e, o);
                end
            end
            if (n == int'(LAT) + 1) begin
                checks++;
                if (code_out !== exp_code || err_out !== e || ovf_out !== o) begin
                    errors++;
                    $display("FAIL %s hold: code=%h err=%b ovf=%b, want code=%h err=%b ovf=%b",
                             name, code_out, err_out, ovf_out, exp_code, e, o);
                end
            end
            if (n == 1) begin
                valid_in = 1'b0;
                mode_in  = ~m;
                data_in  = {$urandom, $urandom, $urandom};
            end
        end
    endtask

    task automatic test_nominal();
        pulse_and_check("nominal", {40'h0, 40'h00_0000_FFFF}, 1'b0, 16, 0, 2'b00, 2'b00);
    endtask

    task automatic test_overflow();
        pulse_and_check("overflow", {40'h1, {W{1'b1}}}, 1'b0, 40, 1, 2'b00, 2'b01);
    endtask

    task automatic test_bubble();
        pulse_and_check("bubble_raw",  {40'h0, 40'h00_000F_FBFF}, 1'b0, 20, 0, 2'b01, 2'b00);
        pulse_and_check("bubble_filt", {40'h0, 40'h00_000F_FBFF}, 1'b1, 20, 0, 2'b00, 2'b00);
        pulse_and_check("bubble_wide", {40'h0, 40'h00_000F_F3FF}, 1'b1, 20, 0, 2'b01, 2'b00);
    endtask

    task automatic test_streaming();
        localparam int N = 400;
        exp_t x;
        for (int t = 0; t < N + int'(LAT) + 2; t++) begin
            @(negedge clk);
            checks++;
            if (q.size() > 0 && q[0].cyc == cyc) begin
                if (valid_out !== 1'b1 || code_out !== q[0].code ||
                    err_out !== q[0].err || ovf_out !== q[0].ovf) begin
                    errors++;
                    $display("FAIL stream_sample: v=%b code=%h err=%b ovf=%b, want v=1 code=%h err=%b ovf=%b",
                             valid_out, code_out, err_out, ovf_out, q[0].code, q[0].err, q[0].ovf);
                end
                void'(q.pop_front());
            end else if (valid_out !== 1'b0) begin
                errors++;
                $display("FAIL stream_gap: valid_out=%b, want 0", valid_out);
            end
            if (t < N) begin
                valid_in = ($urandom_range(0, 3) != 0);
                mode_in  = 1'($urandom);
                data_in  = {gen_vec(), gen_vec()};
                if (valid_in) begin
                    x = model_all(data_in, mode_in, cyc + int'(LAT));
                    q.push_back(x);
                end
            end else begin
                valid_in = 1'b0;
            end
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL stream_drain: %0d samples missing, want 0", q.size());
            q.delete();
        end
    endtask

    task automatic test_reset_midstream();
        exp_t x;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            valid_in = 1'b1;
            mode_in  = 1'($urandom);
            data_in  = {gen_vec(), gen_vec()};
        end
        @(negedge clk);
        valid_in = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        checks++;
        if (valid_out !== 1'b0 || code_out !== '0 || err_out !== '0 || ovf_out !== '0) begin
            errors++;
            $display("FAIL midreset_clear: v=%b code=%h err=%b ovf=%b, want all zero",
                     valid_out, code_out, err_out, ovf_out);
        end
        rst_n = 1'b1;
        for (int n = 0; n < int'(LAT) + 3; n++) begin
            @(negedge clk);
            checks++;
            if (valid_out !== 1'b0) begin
                errors++;
                $display("FAIL midreset_flush: cycle %0d valid_out=%b, want 0", n, valid_out);
            end
        end
        valid_in = 1'b1;
        mode_in  = 1'b1;
        data_in  = {gen_vec(), gen_vec()};
        x = model_all(data_in, mode_in, 0);
        for (int n = 1; n <= int'(LAT); n++) begin
            @(negedge clk);
            if (n == 1) valid_in = 1'b0;
            checks++;
            if (valid_out !== (n == int'(LAT))) begin
                errors++;
                $display("FAIL midreset_latency: cycle %0d valid_out=%b, want %b",
                         n, valid_out, (n == int'(LAT)));
            end
        end
        checks++;
        if (code_out !== x.code || err_out !== x.err || ovf_out !== x.ovf) begin
            errors++;
            $display("FAIL midreset_value: code=%h err=%b ovf=%b, want code=%h err=%b ovf=%b",
                     code_out, err_out, ovf_out, x.code, x.err, x.ovf);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_overflow();
        test_bubble();
        test_streaming();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tdc_thermo_encoder.md
# tdc_thermo_encoder

Parametrised, multi-channel, pipelined thermometer-to-binary encoder for the TDC tapped-delay-line front end. Each cycle it accepts one delay-line snapshot per channel. It optionally removes single-bit bubbles, finds the thermometer edge by pipelined bisection (one result bit per stage), and emits the binary tap count with error and overflow flags. It sits between the delay-line sampling registers and the fine-time calibration/histogram logic, and generalises the fixed 40-bit two-channel decoder with valid tracking, reset, bubble handling and status flags.

## Interface
- `CH`, default 2: number of independent channels.
- `WIDTH`, default 40: delay-line taps per channel.
- `L`, derived as clog2(WIDTH+1) (6 for WIDTH=40): number of bisection stages and the code width. Padded width P = 2^L.
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `valid_in`, in, 1: a snapshot is present on `data_in` this cycle.
- `mode_in`, in, 1: 0 = raw, 1 = bubble-filter. Sampled with `valid_in`.
- `data_in`, in, CH*WIDTH: channel c occupies bits [c*WIDTH +: WIDTH]. Bit 0 is the first tap.
- `valid_out`, out, 1: `code_out`, `err_out` and `ovf_out` are valid.
- `code_out`, out, CH*L: channel c code at [c*L +: L]. This is the tap count.
- `err_out`, out, CH: after filtering, a 0 lies below a 1 (bubble).
- `ovf_out`, out, CH: code equals WIDTH (the line overran).

## Operation
- Stage 0 registers `data_in`, `mode_in` and `valid_in`.
- Stage F (filter):
  - mode 1: bit i becomes maj(b[i-1], b[i], b[i+1]). The virtual bit b[-1] is 1 and b[WIDTH] is 0.
  - mode 0: bits pass through unchanged.
  - The vector is zero-padded to P bits.
  - err = OR over i of (~b[i] & b[i+1]) on the filtered vector. This flag travels with the sample.
- Stages S(L-1)..S0 perform the bisection:
  - k starts at 0.
  - At stage j, if padded bit (k | 2^j) - 1 is 1, set k[j].
  - Each stage forwards only the surviving half of the vector, so stage j holds 2^(j+1) - 1 bits plus the partial k.
- The output stage registers k, err, ovf (= (k == WIDTH)) and valid.
- Mode is captured per sample. Changing `mode_in` never affects samples already in flight.
- Invalid cycles still advance the pipeline. Data with valid = 0 is don't-care, but its valid bit must propagate as 0.
- Channels are fully independent and share one valid/mode pipeline.

## Timing
- Latency LAT = L + 3 cycles from the `valid_in` edge to `valid_out` (9 for WIDTH=40).
- Throughput is one sample per cycle with no stalls. There is no backpressure.
- Reset (async assert, registered release) clears:
  - all pipeline valid bits;
  - `valid_out`, `code_out`, `err_out` and `ovf_out` to 0.
- Samples in flight at reset are discarded. After release, `valid_out` stays 0 until LAT cycles after the first new `valid_in`.
- Outputs hold their last value while `valid_out` = 0.

## Structure
- Package `tdc_pkg`:
  - constant function `clog2`;
  - localparams `MODE_RAW` = 0 and `MODE_FILT` = 1.
- Sub-module `tdc_thermo_lane`, one channel: filter, bisection stages and flag registers, parametrised by WIDTH.
- The top level instantiates CH lanes through `generate` and owns the shared valid/mode shift register.

## Test plan
- Reset: hold `rst_n` = 0 and toggle inputs. Required: all outputs are 0. After release with no `valid_in`, `valid_out` stays 0.
- Nominal edge (CH=2, WIDTH=40): ch0 = 40'h00_0000_FFFF, ch1 = 0, mode 0, one pulse. Required: exactly cycle 9 later, `valid_out` = 1, codes 16/0, err 0/0, ovf 0/0.
- Overflow and empty: ch0 = all ones, ch1 = 40'h1. Required: codes 40/1, ovf 1/0.
- Bubble: ch0 has ones at bits 0..19 with bit 10 cleared.
  - mode 0: code 20, err 1.
  - mode 1: code 20, err 0.
  - Bits 10 and 11 both cleared, mode 1: code 20, err 1.
- Streaming: random thermometer and bubble vectors on every cycle, with `mode_in` toggling and valid gaps. Required: the output stream matches a bit-accurate reference model, in order, with per-sample mode respected.
- Reset mid-stream: pulse `rst_n` low for one cycle while 3 samples are in flight. Required: none of the 3 samples appears. The first post-reset sample emerges after LAT cycles.
